// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and branch-operand
// hazards, multi-cycle mult/div occupancy of EX, dmem wait freeze, stats counters.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic             id_md,
  input  logic             BJ,
  input  logic [4:0]       ex_td,
  input  logic             ex_WREG,
  input  logic             ex_LW,
  input  logic [4:0]       mem_td,
  input  logic             mem_LW,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_hold,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);
  localparam logic       MD_MULTI = (MD_LAT > 1);

  state_t     state;
  logic [3:0] md_cnt;

  logic ex_match, mem_match, load_use, br_haz, haz, md_issue;

  // $zero is hardwired, so a zero destination never forms a dependency
  assign ex_match  = (ex_td != 5'd0) &&
                     ((id_use_rs && id_rs == ex_td) || (id_use_rt && id_rt == ex_td));
  assign mem_match = (mem_td != 5'd0) &&
                     ((id_use_rs && id_rs == mem_td) || (id_use_rt && id_rt == mem_td));
  assign load_use  = ex_LW && ex_match;
  assign br_haz    = id_branch && ((ex_WREG && ex_match) || (mem_LW && mem_match));
  assign haz       = load_use || br_haz;
  assign md_issue  = MD_MULTI && (state == RUN) && id_md && !haz && dmem_ready;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    md_busy     = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (!dmem_ready) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      ex_hold  = 1'b1;
      md_busy  = (state == MD_BUSY);
    end else if (state == MD_BUSY) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      ex_hold  = 1'b1;
      md_busy  = 1'b1;
    end else if (haz) begin
      // branch outcome is not trustworthy until its operands are ready
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (BJ) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      md_cnt    <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (dmem_ready) begin
        case (state)
          RUN: if (md_issue) begin
            state  <= MD_BUSY;
            md_cnt <= MD_INIT;
          end
          MD_BUSY: begin
            md_cnt <= md_cnt - 4'd1;
            if (md_cnt == 4'd1) state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
